// File: rtl/vga_sync_decoder_if.sv
// Bus between a TinyVGA PMOD byte source and vga_sync_decoder.
// The master drives the PMOD byte; the slave returns recovered pixel, lock and CRC information.
interface vga_sync_decoder_if;
    logic [7:0]  vga_in;
    logic        px_valid;
    logic [9:0]  px_x;
    logic [9:0]  px_y;
    logic [5:0]  px_rgb;
    logic        frame_start;
    logic        locked;
    logic        line_err;
    logic [15:0] frame_crc;
    logic        frame_crc_valid;

    modport master (
        output vga_in,
        input  px_valid, px_x, px_y, px_rgb, frame_start, locked, line_err,
               frame_crc, frame_crc_valid
    );

    modport slave (
        input  vga_in,
        output px_valid, px_x, px_y, px_rgb, frame_start, locked, line_err,
               frame_crc, frame_crc_valid
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// VGA receive-side decoder: locks to hsync/vsync in a TinyVGA PMOD byte and recovers x/y/colour.
// Define FRAME_CRC_EN to add a CRC-16-CCITT over the active pixels of each locked frame.
//
// state    | meaning
// UNLOCKED | searching for a clean frame of V_TOTAL lines
// LOCKED   | timing verified; px_valid and frame_start enabled
module vga_sync_decoder #(
    parameter int H_DISPLAY       = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_DISPLAY       = 480,
    parameter int V_BOTTOM        = 10,
    parameter int V_SYNC          = 2,
    parameter int V_TOP           = 33,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    vga_sync_decoder_if.slave  bus
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_HS     = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] Y_VS     = 10'(V_DISPLAY + V_BOTTOM);
    localparam logic [9:0] X_ACT    = 10'(H_DISPLAY);
    localparam logic [9:0] Y_ACT    = 10'(V_DISPLAY);
    localparam logic [9:0] TMR_LOAD = 10'(H_TOTAL - 1);
    localparam logic [9:0] LINES    = 10'(V_TOTAL);
    // Idle input pattern keeps both syncs deasserted so reset release is not seen as an edge.
    localparam logic [7:0] IN_IDLE  = {SYNC_ACTIVE_LOW, 3'b000, SYNC_ACTIVE_LOW, 3'b000};

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t      state, state_nxt;
    logic [7:0]  in_q;
    logic        hs_prev, vs_prev;
    logic [9:0]  x, y;
    logic [9:0]  line_tmr;
    logic        line_armed, line_exp;
    logic [9:0]  line_cnt;
    logic        vs_seen, err_seen;
    logic [5:0]  rgb_q;
    logic        valid_q, fs_q, err_q;

    logic        hs, vs, hs_edge, vs_edge, x_wrap;
    logic [9:0]  x_nxt, y_nxt, tmr_nxt, lcnt_nxt;
    logic        exp_nxt, err_nxt, frame_good, locked_nxt;

    always_comb begin
        hs       = in_q[7] ^ SYNC_ACTIVE_LOW;
        vs       = in_q[3] ^ SYNC_ACTIVE_LOW;
        hs_edge  = hs & ~hs_prev;
        vs_edge  = vs & ~vs_prev;
        x_wrap   = ~hs_edge & (x == X_LAST);
        x_nxt    = x + 10'd1;
        y_nxt    = y;
        tmr_nxt  = line_tmr;
        exp_nxt  = line_exp;
        err_nxt  = 1'b0;
        lcnt_nxt = line_cnt;

        if (hs_edge)
            x_nxt = X_HS;
        else if (x_wrap)
            x_nxt = 10'd0;

        if (vs_edge)
            y_nxt = Y_VS;
        else if (x_wrap)
            y_nxt = (y == Y_LAST) ? 10'd0 : y + 10'd1;

        // Line timer counts down from H_TOTAL-1; an edge is on time only at terminal count.
        if (hs_edge) begin
            err_nxt = line_armed & ((line_tmr != 10'd0) | line_exp);
            tmr_nxt = TMR_LOAD;
            exp_nxt = 1'b0;
        end else if (line_tmr != 10'd0) begin
            tmr_nxt = line_tmr - 10'd1;
        end else if (line_armed & ~line_exp) begin
            err_nxt = 1'b1;
            exp_nxt = 1'b1;
        end

        if (vs_edge)
            lcnt_nxt = hs_edge ? 10'd1 : 10'd0;
        else if (hs_edge && line_cnt != 10'h3FF)
            lcnt_nxt = line_cnt + 10'd1;

        frame_good = vs_seen & (line_cnt == LINES) & ~err_seen & ~err_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            UNLOCKED: if (vs_edge && frame_good) state_nxt = LOCKED;
            LOCKED:   if (err_nxt || (vs_edge && line_cnt != LINES)) state_nxt = UNLOCKED;
            default:  state_nxt = UNLOCKED;
        endcase
        locked_nxt = (state_nxt == LOCKED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= UNLOCKED;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_q       <= IN_IDLE;
            hs_prev    <= 1'b0;
            vs_prev    <= 1'b0;
            x          <= 10'd0;
            y          <= 10'd0;
            line_tmr   <= 10'd0;
            line_armed <= 1'b0;
            line_exp   <= 1'b0;
            line_cnt   <= 10'd0;
            vs_seen    <= 1'b0;
            err_seen   <= 1'b0;
            rgb_q      <= 6'd0;
            valid_q    <= 1'b0;
            fs_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            in_q       <= bus.vga_in;
            hs_prev    <= hs;
            vs_prev    <= vs;
            x          <= x_nxt;
            y          <= y_nxt;
            line_tmr   <= tmr_nxt;
            line_armed <= line_armed | hs_edge;
            line_exp   <= exp_nxt;
            line_cnt   <= lcnt_nxt;
            vs_seen    <= vs_seen | vs_edge;
            err_seen   <= vs_edge ? 1'b0 : (err_seen | err_nxt);
            rgb_q      <= {in_q[0], in_q[4], in_q[1], in_q[5], in_q[2], in_q[6]};
            valid_q    <= locked_nxt & (x_nxt < X_ACT) & (y_nxt < Y_ACT);
            fs_q       <= locked_nxt & (x_nxt == 10'd0) & (y_nxt == 10'd0);
            err_q      <= err_nxt;
        end
    end

    assign bus.px_valid    = valid_q;
    assign bus.px_x        = x;
    assign bus.px_y        = y;
    assign bus.px_rgb      = rgb_q;
    assign bus.frame_start = fs_q;
    assign bus.locked      = (state == LOCKED);
    assign bus.line_err    = err_q;

`ifdef FRAME_CRC_EN
    logic [15:0] crc_acc, crc_upd, crc_q;
    logic        crc_live, crc_v;

    function automatic logic [15:0] crc_byte(input logic [15:0] seed, input logic [7:0] data);
        logic [15:0] c;
        c = seed;
        for (int i = 7; i >= 0; i--)
            c = {c[14:0], 1'b0} ^ ((c[15] ^ data[i]) ? 16'h1021 : 16'h0000);
        return c;
    endfunction

    always_comb crc_upd = crc_byte(fs_q ? 16'hFFFF : crc_acc, {2'b00, rgb_q});

    // crc_live marks a frame whose every active pixel was seen while locked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_acc  <= 16'h0000;
            crc_q    <= 16'h0000;
            crc_live <= 1'b0;
            crc_v    <= 1'b0;
        end else begin
            crc_v <= 1'b0;
            if (state != LOCKED)
                crc_live <= 1'b0;
            else if (fs_q)
                crc_live <= 1'b1;
            if (valid_q)
                crc_acc <= crc_upd;
            if (valid_q && x == X_ACT - 10'd1 && y == Y_ACT - 10'd1 && (crc_live || fs_q)) begin
                crc_q <= crc_upd;
                crc_v <= 1'b1;
            end
        end
    end

    assign bus.frame_crc       = crc_q;
    assign bus.frame_crc_valid = crc_v;
`else
    assign bus.frame_crc       = 16'h0000;
    assign bus.frame_crc_valid = 1'b0;
`endif
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a reduced 56x17 raster (40x10 active).
// A bench-side raster source drives the PMOD byte and records its own sync edges and pixels.
module tb_vga_sync_decoder;
    localparam int HD = 40, HF = 4, HS = 8, HB = 4, HT = HD + HF + HS + HB;
    localparam int VD = 10, VB = 2, VS = 2, VTP = 3, VTOT = VD + VB + VS + VTP;
    localparam int FRAME = HT * VTOT;
    // Source starts at (20,3); 1st vs edge at sample 484, 2nd at 1436, output 2 clocks later.
    localparam int EXP_LOCK = (HT - 20) + (VD + VB - 4) * HT + FRAME + 2;
    localparam int EXP_FS   = EXP_LOCK + (VTOT - (VD + VB)) * HT;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vga_sync_decoder_if bus();

    vga_sync_decoder #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VS), .V_TOP(VTP),
        .SYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_chk, n_err;
    int step_n, cur_k, sx, sy, colour_mode;
    bit hs_off, short_req, short_watch, prev_hs_a, prev_vs_a;
    int short_edge_k, last_hs_edge, last_px_k, nz_cnt;
    int hx[$], hy[$], hrgb[$], vs_q[$];
    int t, t2, cnt, mism, rgb37, vc0, le, s;
    logic [15:0] crc_got;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_model(input int n, input logic [7:0] b);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {b, 8'h00};
            for (int j = 0; j < 8; j++)
                c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // One pixel clock of the source: drive sample cur_k, record it, advance the raster.
    task automatic step();
        logic hs_a, vs_a;
        logic [5:0] rgb;
        @(posedge clk);
        #1;
        if (bus.frame_crc != 16'h0000 || bus.frame_crc_valid) nz_cnt++;
        cur_k = step_n;
        hs_a = (sx >= HD + HF) && (sx < HD + HF + HS) && !hs_off;
        vs_a = (sy >= VD + VB) && (sy < VD + VB + VS);
        case (colour_mode)
            1:       rgb = 6'(sx);
            2:       rgb = 6'h3F;
            default: rgb = 6'h00;
        endcase
        if (!(sx < HD && sy < VD)) rgb = 6'h00;
        bus.vga_in = {~hs_a, rgb[0], rgb[2], rgb[4], ~vs_a, rgb[1], rgb[3], rgb[5]};
        if (hs_a && !prev_hs_a) begin
            last_hs_edge = cur_k;
            if (short_watch) begin
                short_edge_k = cur_k;
                short_watch  = 1'b0;
            end
        end
        if (vs_a && !prev_vs_a) vs_q.push_back(cur_k);
        if (sx == HD - 1 && sy == VD - 1) last_px_k = cur_k;
        prev_hs_a = hs_a;
        prev_vs_a = vs_a;
        hx.push_back(sx);
        hy.push_back(sy);
        hrgb.push_back(int'(rgb));
        if (short_req && sx == 20 && sy == 2) begin
            sx = 22;
            short_req = 1'b0;
            short_watch = 1'b1;
        end else if (sx == HT - 1) begin
            sx = 0;
            sy = (sy == VTOT - 1) ? 0 : sy + 1;
        end else begin
            sx++;
        end
        step_n++;
    endtask

    initial begin
        n_chk = 0; n_err = 0; step_n = 0; cur_k = 0; nz_cnt = 0;
        sx = 20; sy = 3; colour_mode = 0;
        hs_off = 0; short_req = 0; short_watch = 0; prev_hs_a = 0; prev_vs_a = 0;
        short_edge_k = -100; last_hs_edge = -100; last_px_k = -100; crc_got = 16'h0;
        reset = 1'b1;
        bus.vga_in = 8'h88;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", bus.px_x, 0);
        chk("rst_y", bus.px_y, 0);
        chk("rst_flags", {bus.px_valid, bus.frame_start, bus.locked, bus.line_err, bus.frame_crc_valid}, 0);
        chk("rst_rgb_crc", {bus.px_rgb, bus.frame_crc}, 0);
        @(negedge clk);
        reset = 1'b0;

        // Lock on the 2nd vs edge, black pixels
        t = -1; t2 = 0;
        for (int i = 0; i < 3000 && t < 0; i++) begin
            t2 = int'(bus.locked);
            step();
            if (bus.locked) t = cur_k;
        end
        chk("lock_step", t, EXP_LOCK);
        chk("lock_prev", t2, 0);

        t = -1;
        for (int i = 0; i < 2 * FRAME && t < 0; i++) begin
            step();
            if (bus.frame_start) t = cur_k;
        end
        chk("fs_first", t, EXP_FS);
        cnt = 0; t2 = -1;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (bus.frame_start) begin
                cnt++;
                t2 = cur_k;
            end
        end
        chk("fs_count", cnt, 1);
        chk("fs_period", t2 - t, FRAME);

        // Colour = x[5:0]: every output must equal the source sample two clocks earlier
        colour_mode = 1; mism = 0; rgb37 = -1;
        for (int i = 0; i < FRAME; i++) begin
            step();
            s = cur_k - 2;
            if (int'(bus.px_x) != hx[s]) mism++;
            if (int'(bus.px_y) != hy[s]) mism++;
            if (int'(bus.px_rgb) != hrgb[s]) mism++;
            if (bus.px_valid != (hx[s] < HD && hy[s] < VD)) mism++;
            if (!bus.locked) mism++;
            if (bus.px_x == 10'd37 && bus.px_y == 10'd4) rgb37 = int'(bus.px_rgb);
        end
        chk("stream_mism", mism, 0);
        chk("rgb_at_x37", rgb37, 37);

        // One 55-clock line: error, unlock, relock at the vs edge closing the next clean frame
        short_req = 1'b1;
        t = -1;
        for (int i = 0; i < 2 * FRAME && t < 0; i++) begin
            step();
            if (bus.line_err) t = cur_k;
        end
        chk("short_err_step", t, short_edge_k + 2);
        chk("short_unlock", bus.locked, 0);
        vc0 = vs_q.size(); cnt = 0; t = -1;
        for (int i = 0; i < 3 * FRAME && t < 0; i++) begin
            step();
            if (bus.locked) t = cur_k;
            else if (bus.px_valid) cnt++;
        end
        chk("valid_unlocked", cnt, 0);
        chk("relock_step", t, (vs_q.size() > vc0 + 1) ? vs_q[vc0 + 1] + 2 : -2);

        // hsync held deasserted: one timeout pulse HT clocks after the last edge
        for (int i = 0; i < HT && sx != 0; i++) step();
        hs_off = 1'b1;
        le = last_hs_edge; cnt = 0; t = -1;
        for (int i = 0; i < 4 * HT; i++) begin
            step();
            if (bus.line_err) begin
                cnt++;
                if (t < 0) t = cur_k;
            end
        end
        chk("timeout_count", cnt, 1);
        chk("timeout_step", t, le + HT + 2);
        chk("timeout_unlock", bus.locked, 0);
        for (int i = 0; i < HT && sx != 0; i++) step();
        hs_off = 1'b0;

        // Asynchronous reset mid-frame, then reacquire lock
        for (int i = 0; i < 3 * FRAME && !bus.locked; i++) step();
        for (int i = 0; i < FRAME && !bus.px_valid; i++) step();
        chk("pre_reset_valid", bus.px_valid, 1);
        #3 reset = 1'b1;
        #1;
        chk("async_rst_flags", {bus.px_valid, bus.frame_start, bus.locked, bus.line_err, bus.frame_crc_valid}, 0);
        chk("async_rst_xy", {bus.px_x, bus.px_y}, 0);
        chk("async_rst_rgb", {bus.px_rgb, bus.frame_crc}, 0);
        step();
        step();
        @(negedge clk);
        reset = 1'b0;
        vc0 = vs_q.size(); t = -1;
        for (int i = 0; i < 3 * FRAME && t < 0; i++) begin
            step();
            if (bus.locked) t = cur_k;
        end
        chk("reset_relock", t, (vs_q.size() > vc0 + 1) ? vs_q[vc0 + 1] + 2 : -2);

`ifdef FRAME_CRC_EN
        colour_mode = 2; t = -1;
        for (int i = 0; i < 2 * FRAME && t < 0; i++) begin
            step();
            if (bus.frame_crc_valid) begin
                t = cur_k;
                crc_got = bus.frame_crc;
            end
        end
        chk("crc_value", crc_got, crc_model(HD * VD, 8'h3F));
        chk("crc_step", t, last_px_k + 3);
        step();
        chk("crc_pulse_width", bus.frame_crc_valid, 0);
`else
        colour_mode = 2;
        for (int i = 0; i < FRAME; i++) step();
        chk("crc_off", nz_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
